// File: rtl/note_pkg.sv
// Shared constants for the note player: note word field positions, widths and FSM encoding.
package note_pkg;

  localparam int ADDR_W    = 6;
  localparam int WORD_W    = 32;
  localparam int VALID_BIT = 31;
  localparam int LANES_MSB = 29;
  localparam int LANES_LSB = 24;
  localparam int DUR_MSB   = 23;
  localparam int DUR_LSB   = 20;
  localparam int HP_MSB    = 19;
  localparam int HP_LSB    = 0;
  localparam int LANES_W   = LANES_MSB - LANES_LSB + 1;
  localparam int DUR_W     = DUR_MSB - DUR_LSB + 1;
  localparam int HP_W      = HP_MSB - HP_LSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    PLAY  = 2'd3
  } state_t;

  // A programmed duration of 0 still sounds for one beat.
  function automatic logic [DUR_W-1:0] beats_of(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// Square-wave generator: 20-bit down-counter reloading half_period-1, toggling tone on each reload.
module tone_gen
  import note_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            restart,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            tone
);

  logic [HP_W-1:0] cnt_reg;
  logic            tone_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg  <= '0;
      tone_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg  <= half_period - HP_W'(1);
      tone_reg <= 1'b0;
    end else if (enable) begin
      if (cnt_reg == '0) begin
        cnt_reg <= half_period - HP_W'(1);
        // Half periods below 2 would be inaudible buzz; keep the output silent.
        if (half_period >= HP_W'(2))
          tone_reg <= ~tone_reg;
      end else begin
        cnt_reg <= cnt_reg - HP_W'(1);
      end
    end
  end

  assign tone = tone_reg;

endmodule

// File: rtl/note_player.sv
// Fetches a note word from the note RAM on each tempo tick and plays it as a tone plus lane pattern.
// Optional NOTE_PLAYER_STATUS_EN adds a saturating count of started notes (note_count).
module note_player
  import note_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic [ADDR_W-1:0]  address,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [WORD_W-1:0]  rd_data,
  output logic               tone,
  output logic [LANES_W-1:0] lanes,
  output logic               playing
`ifdef NOTE_PLAYER_STATUS_EN
  ,
  output logic [15:0]        note_count
`endif
);

  state_t              state_reg;
  logic                go_d_reg;
  logic                start_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic [LANES_W-1:0]  lanes_reg;
  logic                playing_reg;
  logic [DUR_W-1:0]    beats_reg;
  logic [HP_W-1:0]     hp_reg;

  logic                word_valid;
  logic [LANES_W-1:0]  word_lanes;
  logic [DUR_W-1:0]    word_dur;
  logic [HP_W-1:0]     word_hp;
  logic                start_note;
  logic                stop_note;
  logic [HP_W-1:0]     tone_hp;
  logic                unused_reserved;

  assign word_valid      = rd_data[VALID_BIT];
  assign word_lanes      = rd_data[LANES_MSB:LANES_LSB];
  assign word_dur        = rd_data[DUR_MSB:DUR_LSB];
  assign word_hp         = rd_data[HP_MSB:HP_LSB];
  assign unused_reserved = rd_data[30];

  assign start_note = (state_reg == LATCH) && word_valid;
  assign stop_note  = (state_reg == LATCH) && !word_valid && (beats_reg <= DUR_W'(1));
  assign tone_hp    = start_note ? word_hp : hp_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      go_d_reg    <= 1'b0;
      start_reg   <= 1'b1;
      rd_addr_reg <= '0;
      lanes_reg   <= '0;
      playing_reg <= 1'b0;
      beats_reg   <= '0;
      hp_reg      <= '0;
    end else begin
      go_d_reg <= go;
      case (state_reg)
        IDLE, PLAY: begin
          // The forced first fetch lets word 0 play before upstream moves on.
          if (start_reg) begin
            start_reg   <= 1'b0;
            rd_addr_reg <= '0;
            state_reg   <= FETCH;
          end else if (go_d_reg) begin
            rd_addr_reg <= address;
            state_reg   <= FETCH;
          end
        end
        FETCH: state_reg <= LATCH;
        LATCH: begin
          if (word_valid) begin
            lanes_reg   <= word_lanes;
            beats_reg   <= beats_of(word_dur);
            hp_reg      <= word_hp;
            playing_reg <= 1'b1;
            state_reg   <= PLAY;
          end else if (beats_reg > DUR_W'(1)) begin
            beats_reg <= beats_reg - DUR_W'(1);
            state_reg <= PLAY;
          end else begin
            beats_reg   <= '0;
            lanes_reg   <= '0;
            playing_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .resetn      (resetn),
    .restart     (start_note || stop_note),
    .enable      (playing_reg),
    .half_period (tone_hp),
    .tone        (tone)
  );

`ifdef NOTE_PLAYER_STATUS_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count_reg <= '0;
    else if (start_note && (count_reg != 16'hFFFF))
      count_reg <= count_reg + 16'd1;
  end

  assign note_count = count_reg;
`endif

  assign rd_addr = rd_addr_reg;
  assign lanes   = lanes_reg;
  assign playing = playing_reg;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: a note-level model predicts outputs per edge, a monitor compares.
module tb_note_player;
  import note_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [5:0]  address = '0;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        tone;
  logic [5:0]  lanes;
  logic        playing;
`ifdef NOTE_PLAYER_STATUS_EN
  logic [15:0] note_count;
`endif

  always #5 clk = ~clk;

  note_player dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .address    (address),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tone       (tone),
    .lanes      (lanes),
    .playing    (playing)
`ifdef NOTE_PLAYER_STATUS_EN
    ,
    .note_count (note_count)
`endif
  );

  // Note RAM with one-edge read latency.
  logic [31:0] mem [64];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         due;
    bit         is_addr;
    logic [5:0] addr;
    bit         play;
    logic [5:0] lns;
    int         start;
    int         hp;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Note-level model state.
  bit         m_play = 0;
  logic [5:0] m_lanes = '0;
  int         m_beats = 0;
  int         m_hp = 0;
  int         m_start = 0;
  int         m_count = 0;

  function automatic logic [31:0] word(input bit v, input logic [5:0] ln, input int dur, input int hp);
    return {v, 1'b0, ln, dur[3:0], hp[19:0]};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
  endtask

  // Predict the effect of fetching word fa: rd_addr at due_addr, outputs two edges later.
  task automatic model_fetch(input int due_addr, input logic [5:0] fa);
    exp_t e;
    logic [31:0] w;
    w = mem[fa];
    e = '{due: due_addr, is_addr: 1, addr: fa, play: 0, lns: 0, start: 0, hp: 0, cnt: 0};
    q.push_back(e);
    if (w[31]) begin
      m_play  = 1;
      m_lanes = w[29:24];
      m_beats = (w[23:20] == 0) ? 1 : int'(w[23:20]);
      m_hp    = int'(w[19:0]);
      m_start = due_addr + 2;
      if (m_count < 65535) m_count++;
    end else if (m_beats > 1) begin
      m_beats--;
    end else begin
      m_beats = 0;
      m_play  = 0;
      m_lanes = '0;
    end
    e = '{due: due_addr + 2, is_addr: 0, addr: 0, play: m_play, lns: m_lanes,
          start: m_start, hp: m_hp, cnt: m_count};
    q.push_back(e);
  endtask

  // Tempo tick; dbl repeats go on the next cycle, which the player must drop.
  task automatic tick(input bit dbl);
    logic [5:0] fa;
    fa = address + 6'd1;
    model_fetch(edge_n + 2, fa);
    go = 1'b1;
    @(negedge clk);
    address = address + 6'd1;
    if (dbl) begin
      @(negedge clk);
      address = address + 6'd1;
    end
    go = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_playing"}, int'(playing), 0);
    check({tag, "_lanes"}, int'(lanes), 0);
    check({tag, "_tone"}, int'(tone), 0);
`ifdef NOTE_PLAYER_STATUS_EN
    check({tag, "_count"}, int'(note_count), 0);
`endif
  endtask

  task automatic model_reset();
    exp_t e;
    q.delete();
    m_play = 0; m_lanes = '0; m_beats = 0; m_count = 0;
    e = '{due: edge_n, is_addr: 1, addr: 0, play: 0, lns: 0, start: 0, hp: 0, cnt: 0};
    q.push_back(e);
    e = '{due: edge_n, is_addr: 0, addr: 0, play: 0, lns: 0, start: 0, hp: 0, cnt: 0};
    q.push_back(e);
  endtask

  // Monitor: adopt expectations as they fall due, then compare every cycle.
  logic [5:0] c_addr = '0;
  bit         c_play = 0;
  logic [5:0] c_lanes = '0;
  int         c_start = 0;
  int         c_hp = 0;
  int         c_cnt = 0;
  exp_t       me;
  int         exp_tone;

  always @(negedge clk) begin
    if (resetn) begin
      while (q.size() > 0 && q[0].due <= edge_n) begin
        me = q.pop_front();
        if (me.is_addr) c_addr = me.addr;
        else begin
          c_play = me.play; c_lanes = me.lns; c_start = me.start; c_hp = me.hp; c_cnt = me.cnt;
        end
      end
      exp_tone = (c_play && c_hp >= 2) ? (((edge_n - c_start) / c_hp) % 2) : 0;
      $display("edge %0d: rd_addr=%0d playing=%0d lanes=%b tone=%0d", edge_n, rd_addr, playing, lanes, tone);
      check("rd_addr", int'(rd_addr), int'(c_addr));
      check("playing", int'(playing), int'(c_play));
      check("lanes", int'(lanes), int'(c_lanes));
      check("tone", int'(tone), exp_tone);
`ifdef NOTE_PLAYER_STATUS_EN
      check("note_count", int'(note_count), c_cnt);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = word(1'($urandom_range(0, 1)), 6'($urandom), $urandom_range(0, 15), $urandom_range(0, 12));
    mem[0] = word(1, 6'b000001, 1, 4);
    mem[6] = word(1, 6'b000110, 3, 10);
    for (int i = 7; i <= 10; i++) mem[i] = word(0, 6'($urandom), 0, 3);
    mem[11] = word(1, 6'b110000, 4, 8);
    mem[12] = word(1, 6'b001100, 2, 6);
    mem[13] = word(1, 6'b101010, 0, 1);
    mem[14] = word(0, 6'b111111, 0, 5);
    mem[15] = word(1, 6'b010101, 1, 5);

    // Reset state, then start fetch of word 0 with no tick.
    idle(3);
    check_zero_outputs("reset");
    model_reset();
    resetn = 1'b1;
    model_fetch(edge_n + 1, 6'd0);
    idle(30);

    // Held note across three beats, released on the fourth.
    address = 6'd5;
    for (int i = 0; i < 4; i++) begin tick(0); idle(25); end

    // Long note pre-empted by a new valid note.
    address = 6'd10;
    tick(0); idle(20);
    tick(0); idle(20);

    // Silent note, then release.
    tick(0); idle(10);
    tick(0); idle(10);

    // Back-to-back go: second is dropped.
    tick(1); idle(20);

    // Randomized ticks.
    for (int i = 0; i < 40; i++) begin
      tick(0);
      idle($urandom_range(3, 30));
    end

    // Asynchronous reset mid-note.
    mem[address + 6'd1] = word(1, 6'b100001, 5, 7);
    tick(0); idle(8);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    idle(3);
    address = '0;
    resetn = 1'b1;
    model_fetch(edge_n + 1, 6'd0);
    idle(20);
    for (int i = 0; i < 5; i++) begin
      tick(0);
      idle($urandom_range(3, 20));
    end
    idle(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
